// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings, state enum and decode helpers for the load/store unit
package lsu_pkg;

  localparam int LSU_TIMEOUT = 16;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_RESP   = 2'b10
  } lsu_state_e;

  // Stores only accept signed-width codes; loads also accept the unsigned variants.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    if (is_store) ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else          ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                       (f3 == F3_BU) || (f3 == F3_HU);
    return ok;
  endfunction

  // funct3[1:0] encodes the access size; only meaningful for legal codes.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = addr_lo[0];
      2'b10:   mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane steering for stores and shift/extend for loads
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  we,
  input  logic [2:0]            funct3,
  input  logic [1:0]            addr_lo,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [DATA_WIDTH-1:0] load_word,
  output logic [3:0]            be,
  output logic [DATA_WIDTH-1:0] store_lanes,
  output logic [DATA_WIDTH-1:0] load_data
);

  logic [DATA_WIDTH-1:0] shifted;

  // Store side: replicate narrow data into every lane, enable only the addressed bytes.
  always_comb begin
    be          = 4'b1111;
    store_lanes = store_data;
    if (we) begin
      case (funct3)
        F3_B: begin
          be          = 4'b0001 << addr_lo;
          store_lanes = {(DATA_WIDTH/8){store_data[7:0]}};
        end
        F3_H: begin
          be          = addr_lo[1] ? 4'b1100 : 4'b0011;
          store_lanes = {(DATA_WIDTH/16){store_data[15:0]}};
        end
        default: begin
          be          = 4'b1111;
          store_lanes = store_data;
        end
      endcase
    end
  end

  // Load side: bring the addressed byte/half down to bit 0, then extend.
  always_comb begin
    shifted = load_word >> {addr_lo, 3'b000};
    case (funct3)
      F3_B:    load_data = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      F3_BU:   load_data = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      F3_H:    load_data = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      F3_HU:   load_data = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit with alignment checks and bus timeout
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = lsu_pkg::LSU_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_misaligned,
  output logic                  resp_fault,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  import lsu_pkg::*;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e            state_q, state_d;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  fault_q;
  logic                  mis_q;

  logic                  req_legal;
  logic                  req_mis;
  logic                  accept;
  logic                  expired;
  logic [3:0]            be_steer;
  logic [DATA_WIDTH-1:0] wdata_steer;
  logic [DATA_WIDTH-1:0] load_ext;

  assign req_legal = f3_legal(req_we, funct3);
  assign req_mis   = f3_misaligned(funct3, req_addr[1:0]);
  assign accept    = (state_q == S_IDLE) && req_valid;
  assign expired   = (cnt_q == CNT_LAST);

  lsu_lane_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane_align (
    .we          (we_q),
    .funct3      (funct3_q),
    .addr_lo     (addr_q[1:0]),
    .store_data  (wdata_q),
    .load_word   (mem_rdata),
    .be          (be_steer),
    .store_lanes (wdata_steer),
    .load_data   (load_ext)
  );

  // State register; reset abandons any bus access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake strobes; faulting requests skip the bus entirely.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    mem_req    = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = (!req_legal || req_mis) ? S_RESP : S_ACCESS;
      end
      S_ACCESS: begin
        mem_req = 1'b1;
        if (mem_ack || expired) state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Wait counter: zero outside ACCESS, counts ack-less ACCESS cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                cnt_q <= '0;
    else if ((state_q == S_ACCESS) && !mem_ack) cnt_q <= cnt_q + 1'b1;
    else                                       cnt_q <= '0;
  end

  // Request capture at acceptance and response capture at ack or timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      fault_q  <= 1'b0;
      mis_q    <= 1'b0;
    end else if (accept) begin
      we_q     <= req_we;
      funct3_q <= funct3;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
      rdata_q  <= '0;
      fault_q  <= !req_legal;
      mis_q    <= req_legal && req_mis;
    end else if (state_q == S_ACCESS) begin
      if (mem_ack)      rdata_q <= we_q ? '0 : load_ext;
      else if (expired) fault_q <= 1'b1;
    end
  end

  assign mem_we          = mem_req & we_q;
  assign mem_addr        = mem_req ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign mem_be          = mem_req ? be_steer : 4'b0000;
  assign mem_wdata       = mem_req ? wdata_steer : '0;
  assign resp_rdata      = resp_valid ? rdata_q : '0;
  assign resp_fault      = resp_valid & fault_q;
  assign resp_misaligned = resp_valid & mis_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed bench with a cycle-timeline model of the load/store unit
module tb_load_store_unit;

  localparam int TIMEOUT = 16;
  localparam int DEPTH   = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_misaligned, resp_fault;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  load_store_unit #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .funct3          (funct3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .resp_fault      (resp_fault),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_be          (mem_be),
    .mem_wdata       (mem_wdata),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs per cycle index (cycle i = interval after the i-th rising edge).
  logic        e_ready [DEPTH];
  logic        e_mreq  [DEPTH];
  logic        e_we    [DEPTH];
  logic [31:0] e_addr  [DEPTH];
  logic [3:0]  e_be    [DEPTH];
  logic [31:0] e_wd    [DEPTH];
  logic        e_wcare [DEPTH];
  logic        e_resp  [DEPTH];
  logic [31:0] e_rdata [DEPTH];
  logic        e_mis   [DEPTH];
  logic        e_fault [DEPTH];

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  int          acc_n;
  int          obs_mreq_cnt;
  int          obs_resp_cyc;
  logic [31:0] obs_addr, obs_wd, obs_rdata;
  logic [3:0]  obs_be;
  logic        obs_fault, obs_mis;

  task automatic clear_from(input int c0);
    for (int c = c0; c < DEPTH; c++) begin
      e_ready[c] = 1'b1; e_mreq[c] = 1'b0; e_we[c] = 1'b0; e_addr[c] = '0;
      e_be[c] = '0; e_wd[c] = '0; e_wcare[c] = 1'b0; e_resp[c] = 1'b0;
      e_rdata[c] = '0; e_mis[c] = 1'b0; e_fault[c] = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Model: from the ISA-level meaning of the request, fill the timeline of a request accepted at edge n.
  task automatic predict(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] raw, input int k,
                         input int n, output int r, output bit goes_to_bus);
    bit legal, mis, tmo;
    int size, last;
    logic [31:0] lanes, val, mask;
    logic [3:0] be;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 1 << f3[1:0];
    mis   = legal && ((addr % size) != 0);
    goes_to_bus = legal && !mis;
    if (!goes_to_bus) begin
      e_ready[n] = 1'b0; e_resp[n] = 1'b1; e_fault[n] = !legal; e_mis[n] = mis;
      r = n;
      return;
    end
    tmo  = (k >= TIMEOUT);
    last = n + (tmo ? TIMEOUT - 1 : k);
    lanes = '0;
    if (we) begin
      be = 4'(((1 << size) - 1) << (addr % 4));
      for (int j = 0; j < 4; j++) lanes[8*j +: 8] = wd[8*(j % size) +: 8];
    end else begin
      be = 4'hF;
    end
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 32'd1);
    val  = (raw >> (8*(addr % 4))) & mask;
    if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~mask;
    for (int c = n; c <= last; c++) begin
      e_ready[c] = 1'b0; e_mreq[c] = 1'b1; e_we[c] = we; e_addr[c] = addr & ~32'h3;
      e_be[c] = be; e_wd[c] = lanes; e_wcare[c] = we;
    end
    r = last + 1;
    e_ready[r] = 1'b0; e_resp[r] = 1'b1; e_fault[r] = tmo;
    e_rdata[r] = (we || tmo) ? 32'h0 : val;
  endtask

  // Every cycle: all DUT outputs against the model timeline; also record observations.
  always @(negedge clk) begin
    logic [105:0] got, exp;
    if (chk_en) begin
      got = {req_ready, mem_req, mem_we, mem_addr, mem_be,
             e_wcare[cyc] ? mem_wdata : 32'h0,
             resp_valid, resp_rdata, resp_misaligned, resp_fault};
      exp = {e_ready[cyc], e_mreq[cyc], e_we[cyc], e_addr[cyc], e_be[cyc],
             e_wcare[cyc] ? e_wd[cyc] : 32'h0,
             e_resp[cyc], e_rdata[cyc], e_mis[cyc], e_fault[cyc]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL cycle_%0d outputs: got=%h expected=%h", cyc, got, exp);
      end
      if (mem_req) begin
        obs_mreq_cnt++; obs_addr = mem_addr; obs_be = mem_be; obs_wd = mem_wdata;
      end
      if (resp_valid) begin
        obs_resp_cyc = cyc; obs_rdata = resp_rdata; obs_fault = resp_fault; obs_mis = resp_misaligned;
      end
    end
  end

  // Issue one request at a falling edge, ack it k cycles into ACCESS, return once idle again.
  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] raw, input int k);
    int r;
    bit bus;
    req_valid = 1'b1; req_we = we; funct3 = f3; req_addr = addr; req_wdata = wd;
    acc_n = cyc + 1;
    obs_mreq_cnt = 0; obs_resp_cyc = -1; obs_rdata = 'x; obs_fault = 1'bx; obs_mis = 1'bx;
    predict(we, f3, addr, wd, raw, k, acc_n, r, bus);
    @(negedge clk);
    req_valid = 1'b0; req_we = ~we; funct3 = 3'b111; req_addr = $urandom; req_wdata = $urandom;
    if (bus && k < TIMEOUT) begin
      repeat (k) @(negedge clk);
      mem_ack = 1'b1; mem_rdata = raw;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = $urandom;
    end
    while (cyc <= r) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int r;
    bit bus;
    rst_n = 1'b1; req_valid = 1'b0; req_we = 1'b0; funct3 = 3'b000;
    req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    clear_from(0);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state",
        {req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
         resp_valid, resp_rdata, resp_misaligned, resp_fault},
        {1'b1, 105'd0});
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    txn(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0, 2);
    chk("sb_addr", obs_addr, 32'h0000_1000);
    chk("sb_be", obs_be, 4'b1000);
    chk("sb_wdata", obs_wd, 32'hABAB_ABAB);
    chk("sb_latency", obs_resp_cyc - acc_n, 3);
    chk("sb_fault", obs_fault, 1'b0);

    txn(1'b0, 3'b000, 32'h0000_2001, 32'h0, 32'h0000_8000, 1);
    chk("lb_rdata", obs_rdata, 32'hFFFF_FF80);
    txn(1'b0, 3'b100, 32'h0000_2001, 32'h0, 32'h0000_8000, 0);
    chk("lbu_rdata", obs_rdata, 32'h0000_0080);
    txn(1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 3);
    chk("lhu_rdata", obs_rdata, 32'h0000_BEEF);

    txn(1'b0, 3'b010, 32'h0000_3002, 32'h0, 32'h0, 0);
    chk("lw_mis_flag", obs_mis, 1'b1);
    chk("lw_mis_no_bus", obs_mreq_cnt, 0);
    chk("lw_mis_latency", obs_resp_cyc - acc_n, 0);
    txn(1'b0, 3'b011, 32'h0000_3001, 32'h0, 32'h0, 0);
    chk("illegal_flags", {obs_fault, obs_mis}, 2'b10);

    txn(1'b1, 3'b010, 32'h0000_4000, 32'h1111_2222, 32'h0, 1000);
    chk("timeout_mreq_cycles", obs_mreq_cnt, TIMEOUT);
    chk("timeout_fault", obs_fault, 1'b1);
    chk("timeout_rdata", obs_rdata, 32'h0);

    txn(1'b1, 3'b001, 32'h0000_4006, 32'h1234_ABCD, 32'h0, 1);
    chk("sh_be", obs_be, 4'b1100);
    chk("sh_wdata", obs_wd, 32'hABCD_ABCD);
    txn(1'b0, 3'b001, 32'h0000_4002, 32'h0, 32'h8001_0000, TIMEOUT - 1);
    chk("lh_last_cycle_ack", {obs_fault, obs_rdata}, {1'b0, 32'hFFFF_8001});
    txn(1'b1, 3'b100, 32'h0000_4000, 32'h0, 32'h0, 0);
    txn(1'b0, 3'b010, 32'h0000_7000, 32'h0, 32'h89AB_CDEF, 0);
    txn(1'b0, 3'b101, 32'h0000_7001, 32'h0, 32'h0, 0);
    txn(1'b1, 3'b000, 32'h0000_7000, 32'h0000_0055, 32'h0, 0);

    req_valid = 1'b1; req_we = 1'b1; funct3 = 3'b010;
    req_addr = 32'h0000_5000; req_wdata = 32'h1234_5678;
    predict(1'b1, 3'b010, 32'h0000_5000, 32'h1234_5678, 32'h0, 1000, cyc + 1, r, bus);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    clear_from(cyc);
    #1;
    chk("reset_async_mem_req", mem_req, 1'b0);
    chk("reset_async_ready", req_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    txn(1'b0, 3'b010, 32'h0000_6000, 32'h0, 32'hCAFE_F00D, 1);
    chk("after_reset_lw", {obs_fault, obs_rdata}, {1'b0, 32'hCAFE_F00D});

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, data bus width; ADDR_WIDTH, 32, byte address width; TIMEOUT, 16, max cycles waiting for mem_ack.
REQ-002 Ports SHALL be, in order: clk in 1 clock; rst_n in 1 reset, asynchronous active-low.
REQ-003 req_valid in 1 core request; req_ready out 1 unit can accept; req_we in 1 1=store 0=load; funct3 in 3 RV32 width/sign code; req_addr in ADDR_WIDTH byte address; req_wdata in DATA_WIDTH store data.
REQ-004 resp_valid out 1 one-cycle completion pulse; resp_rdata out DATA_WIDTH extended load data; resp_misaligned out 1 alignment fault; resp_fault out 1 illegal funct3 or bus timeout.
REQ-005 mem_req out 1 memory request; mem_we out 1 write; mem_addr out ADDR_WIDTH word-aligned address; mem_be out 4 byte enables; mem_wdata out DATA_WIDTH lane-steered data; mem_ack in 1 memory done; mem_rdata in DATA_WIDTH raw word.

Function
REQ-006 FSM states SHALL be IDLE, ACCESS, RESP; req_ready SHALL be 1 only in IDLE.
REQ-007 Handshake SHALL complete on the rising edge with req_valid and req_ready both 1; request fields SHALL be registered at that edge.
REQ-008 Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW; all others SHALL be illegal.
REQ-009 Misaligned SHALL be: halfword with addr[0]=1, word with addr[1:0]!=0; bytes never misaligned.
REQ-010 Illegal or misaligned request SHALL go IDLE->RESP without asserting mem_req; resp_fault or resp_misaligned set accordingly (illegal takes priority; only one flag set).
REQ-011 Legal request SHALL go IDLE->ACCESS; mem_req SHALL stay high and mem_addr/mem_we/mem_be/mem_wdata stable until mem_ack is sampled high.
REQ-012 mem_addr SHALL equal {addr[ADDR_WIDTH-1:2],2'b00}.
REQ-013 Store mem_be SHALL be: byte 4'b0001<<addr[1:0]; half 4'b0011 (addr[1]=0) or 4'b1100 (addr[1]=1); word 4'b1111; loads 4'b1111.
REQ-014 Store mem_wdata SHALL replicate the byte into all four lanes for SB, the halfword into both halves for SH, and pass through for SW.
REQ-015 On mem_ack in ACCESS the FSM SHALL go to RESP, capturing mem_rdata shifted right by 8*addr[1:0], then sign-extended (LB/LH) or zero-extended (LBU/LHU); LW unmodified.
REQ-016 A wait counter SHALL clear on entering ACCESS and increment each ACCESS cycle without ack; at TIMEOUT-1 without ack the FSM SHALL drop mem_req, go to RESP, and set resp_fault.
REQ-017 RESP SHALL last exactly one cycle with resp_valid=1, then return to IDLE; no back-pressure on the response.
REQ-018 resp_rdata SHALL be 0 for stores and all faulting responses.
REQ-019 Latency: request accepted edge N, mem_req high cycle N+1; ack sampled at edge N+1+k gives resp_valid during cycle N+2+k; faulting request gives resp_valid during cycle N+1.
REQ-020 mem_ack outside ACCESS SHALL be ignored.

Reset
REQ-021 rst_n low SHALL asynchronously force IDLE, counter 0, req_ready=1, and resp_valid, resp_misaligned, resp_fault, mem_req, mem_we=0, mem_be=0, mem_addr, mem_wdata, resp_rdata=0.
REQ-022 Reset during ACCESS SHALL drop mem_req immediately with no response issued; the abandoned transaction SHALL NOT be replayed.

Structure
REQ-023 Package lsu_pkg SHALL hold funct3 encodings, the state enum, and the TIMEOUT default.
REQ-024 Combinational byte-lane steering and load extension SHALL live in sub-module lsu_lane_align; FSM, counter, and registers stay in load_store_unit.

Verification
REQ-025 SB addr 0x1003 wdata 0xAB, ack after 2 cycles -> mem_addr 0x1000, mem_be 1000, mem_wdata 0xABABABAB, resp_valid 4 cycles after acceptance, no fault.
REQ-026 LB addr 0x2001, mem_rdata 0x0000_8000 -> resp_rdata 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x2002, mem_rdata 0xBEEF1234 -> 0x0000BEEF.
REQ-027 LW addr 0x3002 -> resp_misaligned=1 during the cycle after acceptance, mem_req never asserted; funct3 011 -> resp_fault=1, resp_misaligned=0.
REQ-028 SW with mem_ack held low -> mem_req high exactly TIMEOUT cycles, then resp_fault=1, resp_rdata 0.
REQ-029 rst_n low mid-ACCESS -> mem_req 0 asynchronously, no resp_valid, next request serviced normally; late mem_ack in IDLE ignored.
